// File: rtl/axi4_wr_slave_if.sv
// ---------------------------------------------------------------------------
// axi4_wr_slave_if
// Purpose : AXI4 write-path signal bundle (AW, W and B channels) shared by an
//           interconnect master and a write slave endpoint.
// Ports   : none (signal container)
//   AW*  : burst request   (master -> slave, AWREADY slave -> master)
//   W*   : write data      (master -> slave, WREADY  slave -> master)
//   B*   : write response  (slave -> master, BREADY  master -> slave)
// Modports: master (drives AW/W, BREADY), slave (drives ready lines and B).
// ---------------------------------------------------------------------------
interface axi4_wr_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [7:0]          AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;

  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;

  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output WDATA, WSTRB, WLAST, WVALID,
    output BREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  WDATA, WSTRB, WLAST, WVALID,
    input  BREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID
  );
endinterface

// File: rtl/axi4_wr_slave.sv
// ---------------------------------------------------------------------------
// axi4_wr_slave
// Purpose : AXI4 write slave endpoint. Accepts one burst at a time on AW,
//           turns every W beat into a single-word write on a simple memory
//           port, then answers on B (OKAY, or SLVERR for unsupported size /
//           burst type or a WLAST that disagrees with AWLEN).
// Ports   :
//   ACLK       in   clock, rising edge
//   ARESET     in   synchronous active-high reset
//   s_axi      --   AW/W/B channels (slave modport)
//   mem_we     out  write strobe, one word per cycle
//   mem_addr   out  byte address of the current beat
//   mem_wdata  out  write data (= WDATA)
//   mem_wstrb  out  byte enables (= WSTRB)
//   mem_ready  in   memory accepts the write this cycle
// ---------------------------------------------------------------------------
module axi4_wr_slave #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  axi4_wr_slave_if.slave      s_axi,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready
);

  localparam int              STRB_W    = DATA_W / 8;
  localparam logic [2:0]      SIZE_FULL = 3'($clog2(STRB_W));
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(STRB_W);
  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q,    id_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [7:0]        len_q,   len_d;
  logic [7:0]        cnt_q,   cnt_d;
  logic              incr_q,  incr_d;
  logic              err_q,   err_d;
  logic              cnt_last;

  // NOTE: reset is sampled on the clock edge, and every state register uses
  // non-blocking assignment so all of them update together from _d values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      incr_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      incr_q  <= incr_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal assigned below gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    incr_d        = incr_q;
    err_d         = err_q;
    cnt_last      = (cnt_q == len_q);
    s_axi.AWREADY = 1'b0;
    s_axi.WREADY  = 1'b0;
    s_axi.BVALID  = 1'b0;
    s_axi.BRESP   = RESP_OKAY;
    mem_we        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        s_axi.AWREADY = 1'b1;
        if (s_axi.AWVALID) begin
          id_d    = s_axi.AWID;
          addr_d  = s_axi.AWADDR;
          len_d   = s_axi.AWLEN;
          cnt_d   = '0;
          incr_d  = (s_axi.AWBURST == 2'b01);
          // Only full-width FIXED/INCR bursts are served; WRAP and the
          // reserved encoding both have bit 1 set.
          err_d   = (s_axi.AWSIZE != SIZE_FULL) | s_axi.AWBURST[1];
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        // An erroring burst is drained without touching memory, so it need
        // not wait for the memory to be ready.
        s_axi.WREADY = err_q | mem_ready;
        if (s_axi.WVALID && s_axi.WREADY) begin
          mem_we = ~err_q;
          cnt_d  = cnt_q + 8'd1;
          if (incr_q) addr_d = addr_q + ADDR_INC;
          if (s_axi.WLAST != cnt_last) err_d = 1'b1;
          // Burst closes at whichever comes first: WLAST or the AWLEN count.
          if (s_axi.WLAST || cnt_last) state_d = S_RESP;
        end
      end

      S_RESP: begin
        s_axi.BVALID = 1'b1;
        s_axi.BRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (s_axi.BREADY) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // No memory write may escape while the block is being reset.
    if (ARESET) mem_we = 1'b0;
  end

  assign s_axi.BID = id_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = s_axi.WDATA;
  assign mem_wstrb = s_axi.WSTRB;

endmodule

// File: tb/tb_axi4_wr_slave.sv
// ---------------------------------------------------------------------------
// tb_axi4_wr_slave
// Purpose : directed self-checking bench for axi4_wr_slave. Drives AW/W/B
//           through the interface, records every memory write and compares
//           against hand-computed address/data lists and responses.
// ---------------------------------------------------------------------------
module tb_axi4_wr_slave;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  axi4_wr_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  axi4_wr_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .s_axi     (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory ready: constant 1, or toggling every cycle when enabled.
  bit toggle_en = 1'b0;
  always @(posedge ACLK) begin
    #1;
    mem_ready = toggle_en ? ~mem_ready : 1'b1;
  end

  // Write monitor, sampled mid-cycle.
  int          cyc = 0;
  bit          chk_wr = 1'b0;
  int          wr_viol = 0;
  logic [31:0] act_addr[$];
  logic [35:0] act_data[$];
  int          act_cyc[$];
  logic [31:0] exp_addr[$];
  logic [35:0] exp_data[$];

  always @(posedge ACLK) cyc++;

  always @(negedge ACLK) begin
    if (mem_we === 1'b1) begin
      act_addr.push_back(mem_addr);
      act_data.push_back({mem_wstrb, mem_wdata});
      act_cyc.push_back(cyc);
    end
    if (chk_wr && !mem_ready && bus.WREADY) wr_viol++;
  end

  task automatic expect_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    exp_addr.push_back(addr);
    exp_data.push_back({strb, data});
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, 64'(act_addr.size()), 64'(exp_addr.size()));
    while (exp_addr.size() > 0 && act_addr.size() > 0) begin
      check({tag, "_addr"}, act_addr.pop_front(), exp_addr.pop_front());
      check({tag, "_data"}, act_data.pop_front(), exp_data.pop_front());
    end
    act_addr.delete(); act_data.delete(); act_cyc.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit hs = 1'b0;
    int n = 0;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len;
    bus.AWSIZE = size; bus.AWBURST = burst; bus.AWVALID = 1'b1;
    while (!hs && n < 50) begin
      @(negedge ACLK); hs = bus.AWREADY;
      @(posedge ACLK); #1; n++;
    end
    bus.AWVALID = 1'b0;
    if (!hs) check("aw_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last, input int gap);
    bit hs = 1'b0;
    int n = 0;
    repeat (gap) begin bus.WVALID = 1'b0; @(posedge ACLK); #1; end
    bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
    while (!hs && n < 50) begin
      @(negedge ACLK); hs = bus.WREADY;
      @(posedge ACLK); #1; n++;
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    if (!hs) check("w_timeout", 64'd0, 64'd1);
  endtask

  task automatic get_b(input logic [3:0] id, input logic [1:0] resp, input string tag, output int waits);
    bit hs = 1'b0;
    int n = 0;
    bus.BREADY = 1'b1;
    while (!hs && n < 50) begin
      @(negedge ACLK); hs = bus.BVALID;
      if (hs) begin
        check({tag, "_bid"}, bus.BID, id);
        check({tag, "_bresp"}, bus.BRESP, resp);
      end
      @(posedge ACLK); #1; n++;
    end
    bus.BREADY = 1'b0;
    waits = n;
    if (!hs) check({tag, "_b_timeout"}, 64'd0, 64'd1);
    @(negedge ACLK);
    check({tag, "_awready_after_b"}, bus.AWREADY, 1'b1);
    @(posedge ACLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
    bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
    bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;

    // Reset state
    @(negedge ACLK);
    check("rst_awready", bus.AWREADY, 1'b1);
    check("rst_wready",  bus.WREADY,  1'b0);
    check("rst_bvalid",  bus.BVALID,  1'b0);
    check("rst_bresp",   bus.BRESP,   2'b00);
    check("rst_bid",     bus.BID,     4'h0);
    check("rst_mem_we",  mem_we,      1'b0);
    @(posedge ACLK); #1;

    // W before AW is refused
    bus.WDATA = 32'hDEAD_BEEF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    @(negedge ACLK);
    check("early_w_wready", bus.WREADY, 1'b0);
    @(posedge ACLK); #1;
    bus.WVALID = 1'b0;
    compare_writes("early_w");

    // 1: INCR 0x100 LEN=3 back-to-back
    send_aw(4'h5, 32'h100, 8'd3, 3'd2, 2'b01);
    send_w(32'h1111_0000, 4'hF, 1'b0, 0);
    send_w(32'h1111_0001, 4'hF, 1'b0, 0);
    send_w(32'h1111_0002, 4'hF, 1'b0, 0);
    send_w(32'h1111_0003, 4'hF, 1'b1, 0);
    get_b(4'h5, 2'b00, "t1", w);
    check("t1_b_latency", 64'(w), 64'd1);
    if (act_cyc.size() == 4) check("t1_consecutive", 64'(act_cyc[3] - act_cyc[0]), 64'd3);
    else check("t1_consecutive_cnt", 64'(act_cyc.size()), 64'd4);
    expect_wr(32'h100, 32'h1111_0000, 4'hF);
    expect_wr(32'h104, 32'h1111_0001, 4'hF);
    expect_wr(32'h108, 32'h1111_0002, 4'hF);
    expect_wr(32'h10C, 32'h1111_0003, 4'hF);
    compare_writes("t1");

    // 2: FIXED 0x40 LEN=2
    send_aw(4'hA, 32'h40, 8'd2, 3'd2, 2'b00);
    send_w(32'h2222_0000, 4'h3, 1'b0, 0);
    send_w(32'h2222_0001, 4'hC, 1'b0, 0);
    send_w(32'h2222_0002, 4'hF, 1'b1, 0);
    get_b(4'hA, 2'b00, "t2", w);
    expect_wr(32'h40, 32'h2222_0000, 4'h3);
    expect_wr(32'h40, 32'h2222_0001, 4'hC);
    expect_wr(32'h40, 32'h2222_0002, 4'hF);
    compare_writes("t2");

    // 3: INCR LEN=3, toggling mem_ready and WVALID gaps
    toggle_en = 1'b1;
    chk_wr = 1'b1;
    send_aw(4'h3, 32'h200, 8'd3, 3'd2, 2'b01);
    send_w(32'h3333_0000, 4'hF, 1'b0, 0);
    send_w(32'h3333_0001, 4'hF, 1'b0, 1);
    send_w(32'h3333_0002, 4'hF, 1'b0, 0);
    send_w(32'h3333_0003, 4'hF, 1'b1, 2);
    get_b(4'h3, 2'b00, "t3", w);
    chk_wr = 1'b0;
    toggle_en = 1'b0;
    check("t3_wready_vs_mem_ready", 64'(wr_viol), 64'd0);
    expect_wr(32'h200, 32'h3333_0000, 4'hF);
    expect_wr(32'h204, 32'h3333_0001, 4'hF);
    expect_wr(32'h208, 32'h3333_0002, 4'hF);
    expect_wr(32'h20C, 32'h3333_0003, 4'hF);
    compare_writes("t3");
    @(posedge ACLK); #1;

    // 4a: AWSIZE=1 -> drained, SLVERR, no writes
    send_aw(4'h7, 32'h80, 8'd1, 3'd1, 2'b01);
    send_w(32'h4444_0000, 4'hF, 1'b0, 0);
    send_w(32'h4444_0001, 4'hF, 1'b1, 0);
    get_b(4'h7, 2'b10, "t4a", w);
    compare_writes("t4a");

    // 4b: WRAP -> drained, SLVERR, no writes
    send_aw(4'h8, 32'h90, 8'd1, 3'd2, 2'b10);
    send_w(32'h4444_0002, 4'hF, 1'b0, 0);
    send_w(32'h4444_0003, 4'hF, 1'b1, 0);
    get_b(4'h8, 2'b10, "t4b", w);
    compare_writes("t4b");

    // 5a: LEN=3 but WLAST on second beat
    send_aw(4'h9, 32'h500, 8'd3, 3'd2, 2'b01);
    send_w(32'h5555_0000, 4'hF, 1'b0, 0);
    send_w(32'h5555_0001, 4'hF, 1'b1, 0);
    get_b(4'h9, 2'b10, "t5a", w);
    expect_wr(32'h500, 32'h5555_0000, 4'hF);
    expect_wr(32'h504, 32'h5555_0001, 4'hF);
    compare_writes("t5a");

    // 5b: LEN=1 with WLAST never set
    send_aw(4'hB, 32'h600, 8'd1, 3'd2, 2'b01);
    send_w(32'h5555_0002, 4'hF, 1'b0, 0);
    send_w(32'h5555_0003, 4'hF, 1'b0, 0);
    get_b(4'hB, 2'b10, "t5b", w);
    expect_wr(32'h600, 32'h5555_0002, 4'hF);
    expect_wr(32'h604, 32'h5555_0003, 4'hF);
    compare_writes("t5b");

    // 6a: BREADY held low for 5 cycles
    send_aw(4'hC, 32'h700, 8'd0, 3'd2, 2'b01);
    send_w(32'h6666_0000, 4'hF, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("t6a_bvalid_hold",  bus.BVALID,  1'b1);
      check("t6a_bid_hold",     bus.BID,     4'hC);
      check("t6a_bresp_hold",   bus.BRESP,   2'b00);
      check("t6a_awready_hold", bus.AWREADY, 1'b0);
      @(posedge ACLK); #1;
    end
    get_b(4'hC, 2'b00, "t6a", w);
    expect_wr(32'h700, 32'h6666_0000, 4'hF);
    compare_writes("t6a");

    // 6b: ARESET during the third beat
    send_aw(4'hD, 32'h800, 8'd3, 3'd2, 2'b01);
    send_w(32'h7777_0000, 4'hF, 1'b0, 0);
    send_w(32'h7777_0001, 4'hF, 1'b0, 0);
    bus.WDATA = 32'h7777_0002; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    ARESET = 1'b1;
    @(negedge ACLK);
    check("t6b_mem_we_in_reset", mem_we, 1'b0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    bus.WVALID = 1'b0;
    @(negedge ACLK);
    check("t6b_bvalid_after_rst",  bus.BVALID,  1'b0);
    check("t6b_awready_after_rst", bus.AWREADY, 1'b1);
    check("t6b_wready_after_rst",  bus.WREADY,  1'b0);
    @(posedge ACLK); #1;
    expect_wr(32'h800, 32'h7777_0000, 4'hF);
    expect_wr(32'h804, 32'h7777_0001, 4'hF);
    compare_writes("t6b");

    // Recovery burst after the abandoned one
    send_aw(4'hE, 32'h900, 8'd0, 3'd2, 2'b01);
    send_w(32'h8888_0000, 4'h5, 1'b1, 0);
    get_b(4'hE, 2'b00, "t6c", w);
    expect_wr(32'h900, 32'h8888_0000, 4'h5);
    compare_writes("t6c");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
